// File: rtl/cache_arbiter.sv
// Shares the single cacheline memory port between I-cache and D-cache misses.
// Optional round-robin conflict resolution: define CACHE_ARB_RR_EN.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  wr_q, wr_d;
  logic                  d_req;
  logic                  grant_d;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
  // last_q: 0 = I served last, 1 = D served last
  logic last_q, last_d;

  always_comb begin
    grant_d = d_req & (~i_read | ~last_q);
    last_d  = last_q;
    if (state_q == IDLE && (d_req || i_read))
      last_d = grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`else
  always_comb grant_d = d_req;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    line_d       = line_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_address;
          wdata_d = d_wdata;
          wr_d    = d_write;
        end else if (i_read) begin
          state_d = SERVE_I;
          addr_d  = i_address;
          wdata_d = d_wdata;
          wr_d    = 1'b0;
        end
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = DONE_I;
        end
      end
      SERVE_D: begin
        pmem_read    = ~wr_q;
        pmem_write   = wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wr_q ? wdata_q : '0;
        if (pmem_resp) begin
          if (!wr_q) line_d = pmem_rdata;
          state_d = DONE_D;
        end
      end
      DONE_I: begin
        i_resp  = 1'b1;
        state_d = IDLE;
      end
      DONE_D: begin
        d_resp  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      line_q  <= line_d;
    end
  end

  assign i_rdata = line_q;
  assign d_rdata = line_q;

endmodule
